boa_peri_arbiter: RTL

- Two-requester, round-robin arbiter sharing one MMIO peripheral bus.
- Sits between two bus masters (e.g. CPU data port and a debug/DMA master) and the MMIO peripheral fabric.
- Peripherals are assumed to register read data, valid the cycle after the address is accepted.
- Sequences each access through an address phase and a data phase, then returns a one-cycle ready pulse to the owning requester.

---
 rtl/boa_peri_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/boa_peri_arbiter.sv
// Two-requester round-robin arbiter in front of a registered-read MMIO peripheral bus.
// Define BOA_PERI_ARB_TIMEOUT_EN to abort address phases that wait TIMEOUT cycles.
module boa_peri_arbiter #(
   parameter int ALEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_re,
   input  logic [3:0]      m0_we,
   input  logic [ALEN-1:2] m0_addr,
   input  logic [31:0]     m0_wdata,
   output logic            m0_ready,
   output logic [31:0]     m0_rdata,
   input  logic            m1_re,
   input  logic [3:0]      m1_we,
   input  logic [ALEN-1:2] m1_addr,
   input  logic [31:0]     m1_wdata,
   output logic            m1_ready,
   output logic [31:0]     m1_rdata,
   output logic            p_re,
   output logic [3:0]      p_we,
   output logic [ALEN-1:2] p_addr,
   output logic [31:0]     p_wdata,
   input  logic            p_ready,
   input  logic [31:0]     p_rdata,
   output logic            err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
`ifdef BOA_PERI_ARB_TIMEOUT_EN
   localparam logic [1:0] S_ERR  = 2'd3;
   localparam int         CNT_W  = $clog2(TIMEOUT + 1);
`endif

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("boa_peri_arbiter: TIMEOUT must be at least 1");
   end

   logic [1:0]      state_q, state_d;
   logic            last_q, last_d;
   logic            owner_q, owner_d;
   logic            re_q, re_d;
   logic [3:0]      we_q, we_d;
   logic [ALEN-1:2] addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
`ifdef BOA_PERI_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   logic req0, req1, gnt1;
   logic done;
   logic [31:0] rsp_data;

   assign req0 = m0_re | (|m0_we);
   assign req1 = m1_re | (|m1_we);
   // Under contention the requester that was not served last wins.
   assign gnt1 = req1 & (~req0 | ~last_q);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      re_d    = re_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef BOA_PERI_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               owner_d = gnt1;
               re_d    = gnt1 ? m1_re    : m0_re;
               we_d    = gnt1 ? m1_we    : m0_we;
               addr_d  = gnt1 ? m1_addr  : m0_addr;
               wdata_d = gnt1 ? m1_wdata : m0_wdata;
               state_d = S_ADDR;
`ifdef BOA_PERI_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_ADDR: begin
            if (p_ready) begin
               state_d = S_DATA;
`ifdef BOA_PERI_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         S_DATA: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
`ifdef BOA_PERI_ARB_TIMEOUT_EN
         S_ERR: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 4'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef BOA_PERI_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         re_q    <= re_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef BOA_PERI_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign p_re    = (state_q == S_ADDR) & re_q;
   assign p_we    = (state_q == S_ADDR) ? we_q : 4'b0;
   assign p_addr  = addr_q;
   assign p_wdata = wdata_q;

`ifdef BOA_PERI_ARB_TIMEOUT_EN
   assign done     = (state_q == S_DATA) | (state_q == S_ERR);
   assign rsp_data = (state_q == S_ERR) ? 32'hFFFF_FFFF : p_rdata;
   assign err      = (state_q == S_ERR);
`else
   assign done     = (state_q == S_DATA);
   assign rsp_data = p_rdata;
   assign err      = 1'b0;
`endif

   assign m0_ready = done & ~owner_q;
   assign m1_ready = done & owner_q;
   assign m0_rdata = m0_ready ? rsp_data : 32'h0;
   assign m1_rdata = m1_ready ? rsp_data : 32'h0;

endmodule
